pwm_sample_sequencer: RTL and testbench
=======================================

Name: pwm_sample_sequencer

Overview:
Feeds a PWM DAC from a sample stream. Buffers incoming duty samples in a small FIFO and owns the PWM period counter. Loads each new duty value only at a period boundary, so every period is glitch-free and complete. Sits between a sample producer (DSP/ROM player) and the analogue output pin.

Parameters:
WIDTH, 10, duty/counter width; period = 2^WIDTH clocks
DEPTH, 4, sample FIFO depth; power of 2, >=2
REPEAT_W, 8, width of the periods-per-sample field

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
enable  in  1  run request; level-sensitive
repeat  in  REPEAT_W  periods per sample minus 1; sampled when a sample is loaded
s_valid  in  1  sample valid
s_data  in  WIDTH  unsigned duty sample
s_ready  out  1  FIFO not full
pwm_out  out  1  PWM output, high while duty > count
duty  out  WIDTH  duty value currently in effect
period_start  out  1  one-clock strobe when count == 0 in RUN
busy  out  1  state != IDLE
fifo_level  out  $clog2(DEPTH)+1  samples buffered
underflow  out  1  sticky: boundary reached with FIFO empty
underflow_clr  in  1  clears underflow; set has priority if simultaneous

Behaviour:
- Reset (rst low, async): state IDLE, count 0, duty 0, rep_cnt 0, FIFO empty; pwm_out 0, period_start 0, busy 0, underflow 0, s_ready 0 while rst is low.
- Handshake: a transfer occurs when s_valid && s_ready. s_ready = (fifo_level != DEPTH) and is accepted in every state. A push while full is impossible. A simultaneous push and pop on a full FIFO is not allowed; s_ready is still 0.
- Counter: count increments 0..2^WIDTH-1 and wraps in RUN and STOP. It is held at 0 in IDLE and PRIME.
- pwm_out = (state in RUN/STOP) && (duty > count), registered. duty = 0 gives constant low. duty = 2^WIDTH-1 gives high for all but 1 clock per period.
- FSM:
  - IDLE: when enable=1, go to PRIME.
  - PRIME: when fifo_level != 0, pop a sample into duty, load rep_cnt <= repeat, go to RUN. The next cycle is count 0 and period_start=1. If enable=0, go to IDLE.
  - RUN: at count == 2^WIDTH-1 (boundary):
    - if rep_cnt != 0: rep_cnt--.
    - else, if FIFO is non-empty: pop into duty and reload rep_cnt <= repeat.
    - else: hold duty, set underflow, reload rep_cnt <= 0. A sample arriving later is used at the next boundary.
    - If enable=0 at any cycle, go to STOP.
  - STOP: finish the current period; at the boundary go to IDLE, clearing duty to 0 and count to 0. No pop occurs at this boundary. If enable returns to 1 before the boundary, go back to RUN with no gap.
- FIFO contents persist across IDLE. They are cleared only by rst.
- Latency: the first sample is visible on duty 1 clock after PRIME sees a non-empty FIFO. Each subsequent sample takes effect exactly at count 0 after its boundary.
- fifo_level updates the cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
- repeat changes take effect only at the next sample load.

Optional Feature:
PWM_SEQ_UNDERFLOW_CNT_EN:
- Defined: adds output underflow_count[15:0]. It increments on each underflow boundary, saturates at 16'hFFFF, and is cleared by rst or underflow_clr. If set and clear are simultaneous, the counter becomes 1.
- Undefined: the port is absent; only the sticky underflow flag exists.

Test Plan:
- Reset then idle: rst low mid-RUN with pwm_out=1 -> pwm_out=0, busy=0, fifo_level=0, duty=0 immediately (async).
- Basic stream, WIDTH=4, repeat=0: push 4,8,0,15 then enable -> periods high for 4,8,0,15 clocks out of 16; period_start every 16 clocks; underflow=0.
- Repeat: repeat=2, push 5,10 -> 3 periods at 5-high, then 3 periods at 10-high; pop occurs only every 48 clocks.
- Underflow: push one sample 7, no more -> second period still 7-high, underflow=1. Push 3 mid-period -> next period 3-high. underflow_clr pulse -> 0.
- Full/backpressure: DEPTH=4, enable=0, hold s_valid with 5 samples -> s_ready=0 after 4 accepted, fifo_level=4; 5th accepted one cycle after the first pop.
- Disable mid-period: drop enable at count 6 -> period completes to count 15, then IDLE, pwm_out=0. Re-assert enable at count 10 instead -> no gap, next sample loads normally.

Source files
------------

// File: rtl/pwm_sample_sequencer.sv
// PWM sample sequencer. It buffers duty samples in a small FIFO and runs the
// PWM period counter. A new duty value is loaded only at a period boundary.
// Optional build macro: PWM_SEQ_UNDERFLOW_CNT_EN adds a saturating 16-bit
// underflow event counter on o_underflow_count.
// i_rst is an asynchronous, active-low reset.
module pwm_sample_sequencer #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [REPEAT_W-1:0]     i_repeat,
  input  logic                    i_s_valid,
  input  logic [WIDTH-1:0]        i_s_data,
  output logic                    o_s_ready,
  output logic                    o_pwm_out,
  output logic [WIDTH-1:0]        o_duty,
  output logic                    o_period_start,
  output logic                    o_busy,
  output logic [$clog2(DEPTH):0]  o_fifo_level,
  output logic                    o_underflow,
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
  output logic [15:0]             o_underflow_count,
`endif
  input  logic                    i_underflow_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_STOP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    w_count_nxt;
  logic [WIDTH-1:0]    r_duty;
  logic [WIDTH-1:0]    w_duty_nxt;
  logic [REPEAT_W-1:0] r_rep_cnt;
  logic [REPEAT_W-1:0] w_rep_nxt;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [LW-1:0]       w_level_nxt;
  logic                r_s_ready;
  logic                r_pwm;
  logic                r_period_start;
  logic                r_busy;
  logic                r_underflow;
  logic                w_push;
  logic                w_pop;
  logic                w_nempty;
  logic                w_boundary;
  logic                w_run_bnd;
  logic                w_uf_set;

  assign w_push      = i_s_valid && r_s_ready;
  assign w_nempty    = (r_level != '0);
  assign w_boundary  = (r_count == CNT_MAX);
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // Next-state, counter, duty, repeat and pop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = '0;
    w_duty_nxt  = r_duty;
    w_rep_nxt   = r_rep_cnt;
    w_pop       = 1'b0;
    w_uf_set    = 1'b0;
    w_run_bnd   = 1'b0;
    if (r_state == S_RUN || r_state == S_STOP) begin
      w_count_nxt = r_count + WIDTH'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_nempty) begin
          w_pop       = 1'b1;
          w_duty_nxt  = r_mem[r_rd_ptr];
          w_rep_nxt   = i_repeat;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run_bnd = w_boundary;
        if (!i_enable) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (i_enable) begin
          w_state_nxt = S_RUN;
          w_run_bnd   = w_boundary;
        end else if (w_boundary) begin
          w_state_nxt = S_IDLE;
          w_duty_nxt  = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Period boundary while running: repeat, load next sample, or underflow.
    if (w_run_bnd) begin
      if (r_rep_cnt != '0) begin
        w_rep_nxt = r_rep_cnt - REPEAT_W'(1);
      end else if (w_nempty) begin
        w_pop      = 1'b1;
        w_duty_nxt = r_mem[r_rd_ptr];
        w_rep_nxt  = i_repeat;
      end else begin
        w_uf_set  = 1'b1;
        w_rep_nxt = '0;
      end
    end
  end

  // State, counter and registered outputs, all derived from next-state values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_duty         <= '0;
      r_rep_cnt      <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_busy         <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_duty         <= w_duty_nxt;
      r_rep_cnt      <= w_rep_nxt;
      r_pwm          <= (w_state_nxt == S_RUN || w_state_nxt == S_STOP) &&
                        (w_duty_nxt > w_count_nxt);
      r_period_start <= (w_state_nxt == S_RUN) && (w_count_nxt == '0);
      r_busy         <= (w_state_nxt != S_IDLE);
      if (w_uf_set)             r_underflow <= 1'b1;
      else if (i_underflow_clr) r_underflow <= 1'b0;
    end
  end

  // FIFO pointers, level and ready; ready stays low while reset is held.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level   <= w_level_nxt;
      r_s_ready <= (w_level_nxt != LW'(DEPTH));
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_s_data;
  end

`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_count;

  // Saturating underflow event counter; a set coinciding with clear gives 1.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_uf_count <= '0;
    end else if (w_uf_set && i_underflow_clr) begin
      r_uf_count <= 16'd1;
    end else if (i_underflow_clr) begin
      r_uf_count <= '0;
    end else if (w_uf_set && r_uf_count != 16'hFFFF) begin
      r_uf_count <= r_uf_count + 16'd1;
    end
  end

  assign o_underflow_count = r_uf_count;
`else
  // Only the sticky flag reports underflow in this build.
`endif

  assign o_s_ready      = r_s_ready;
  assign o_pwm_out      = r_pwm;
  assign o_duty         = r_duty;
  assign o_period_start = r_period_start;
  assign o_busy         = r_busy;
  assign o_fifo_level   = r_level;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer with WIDTH=4, DEPTH=4.
// Expected duty per period is queued when samples are pushed and popped
// whenever a PWM period starts.
module tb_pwm_sample_sequencer;

  logic       clk;
  logic       i_rst;
  logic       i_enable;
  logic [7:0] i_repeat;
  logic       i_s_valid;
  logic [3:0] i_s_data;
  logic       o_s_ready;
  logic       o_pwm_out;
  logic [3:0] o_duty;
  logic       o_period_start;
  logic       o_busy;
  logic [2:0] o_fifo_level;
  logic       o_underflow;
  logic       i_underflow_clr;
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
  logic [15:0] o_underflow_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int q[$];

  pwm_sample_sequencer #(.WIDTH(4), .DEPTH(4), .REPEAT_W(8)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_repeat       (i_repeat),
    .i_s_valid      (i_s_valid),
    .i_s_data       (i_s_data),
    .o_s_ready      (o_s_ready),
    .o_pwm_out      (o_pwm_out),
    .o_duty         (o_duty),
    .o_period_start (o_period_start),
    .o_busy         (o_busy),
    .o_fifo_level   (o_fifo_level),
    .o_underflow    (o_underflow),
`ifdef PWM_SEQ_UNDERFLOW_CNT_EN
    .o_underflow_count (o_underflow_count),
`endif
    .i_underflow_clr (i_underflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic push(input logic [3:0] d);
    int n = 0;
    i_s_valid = 1'b1;
    i_s_data  = d;
    while (o_s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", (n < 100) ? 1 : 0, 1);
    @(negedge clk);
    i_s_valid = 1'b0;
  endtask

  task automatic wait_ps(output int w);
    int n = 0;
    while (o_period_start !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("period_start_wait", (n < 64) ? 1 : 0, 1);
    w = n;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (n < 64) ? 1 : 0, 1);
  endtask

  // Sample 16 cycles starting at count 0; returns pwm-high and strobe counts.
  task automatic measure(output int hi, output int ps);
    hi = 0;
    ps = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_pwm_out === 1'b1) hi++;
      if (o_period_start === 1'b1) ps++;
      @(negedge clk);
    end
  endtask

  task automatic check_periods(input int np);
    int w, hi, ps, exp;
    for (int k = 0; k < np; k++) begin
      wait_ps(w);
      if (k > 0) chk("period_spacing", w, 0);
      exp = (q.size() != 0) ? q.pop_front() : -1;
      chk("duty_load", 32'(o_duty), exp);
      measure(hi, ps);
      chk("pwm_high_clocks", hi, exp);
      chk("strobes_per_period", ps, 1);
    end
  endtask

  initial begin
    int w, hi, ps, exp;
    i_rst = 1'b0; i_enable = 1'b0; i_repeat = 8'd0;
    i_s_valid = 1'b0; i_s_data = 4'd0; i_underflow_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_pwm", o_pwm_out, 0);
    chk("rst_duty", o_duty, 0);
    chk("rst_level", o_fifo_level, 0);
    chk("rst_ready", o_s_ready, 0);
    chk("rst_underflow", o_underflow, 0);
    chk("rst_period_start", o_period_start, 0);
    i_rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", o_s_ready, 1);

    // Basic stream: 4, 8, 0, 15 with repeat 0
    foreach (q[i]) q.delete(i);
    push(4); push(8); push(0); push(15);
    q.push_back(4); q.push_back(8); q.push_back(0); q.push_back(15);
    chk("full_level", o_fifo_level, 4);
    chk("full_ready", o_s_ready, 0);
    i_enable = 1'b1;
    check_periods(3);
    chk("no_underflow", o_underflow, 0);
    check_periods(1);
    chk("underflow_set", o_underflow, 1);
    chk("duty_held", o_duty, 15);

    // Underflow hold, then late sample picked up at next boundary
    q.push_back(15); q.push_back(3);
    fork
      check_periods(2);
      begin
        repeat (5) @(negedge clk);
        push(3);
      end
    join
    chk("underflow_sticky", o_underflow, 1);
    i_underflow_clr = 1'b1;
    @(negedge clk);
    i_underflow_clr = 1'b0;
    chk("underflow_cleared", o_underflow, 0);

    // Disable at count 6: period completes, then idle with no pop
    push(9); push(6);
    q.push_back(9);
    wait_ps(w);
    exp = (q.size() != 0) ? q.pop_front() : -1;
    chk("duty_before_stop", 32'(o_duty), exp);
    fork
      measure(hi, ps);
      begin
        repeat (6) @(negedge clk);
        i_enable = 1'b0;
      end
    join
    chk("stop_period_high", hi, 9);
    chk("stop_busy", o_busy, 0);
    chk("stop_pwm", o_pwm_out, 0);
    chk("stop_duty", o_duty, 0);
    chk("stop_no_pop", o_fifo_level, 1);
    chk("stop_no_strobe", o_period_start, 0);

    // Re-enable at count 10: no gap, next sample loads normally
    push(2);
    q.push_back(6); q.push_back(2);
    i_enable = 1'b1;
    wait_ps(w);
    exp = (q.size() != 0) ? q.pop_front() : -1;
    chk("reenable_duty", 32'(o_duty), exp);
    fork
      measure(hi, ps);
      begin
        repeat (6) @(negedge clk);
        i_enable = 1'b0;
        repeat (4) @(negedge clk);
        i_enable = 1'b1;
      end
    join
    chk("reenable_period_high", hi, 6);
    chk("reenable_no_gap", o_period_start, 1);
    exp = (q.size() != 0) ? q.pop_front() : -1;
    chk("reenable_next_duty", 32'(o_duty), exp);
    chk("reenable_busy", o_busy, 1);
    measure(hi, ps);
    chk("reenable_next_high", hi, 2);
    i_enable = 1'b0;
    wait_idle();
    i_underflow_clr = 1'b1;
    @(negedge clk);
    i_underflow_clr = 1'b0;

    // Repeat = 2: each sample lasts three periods
    i_repeat = 8'd2;
    push(5); push(10);
    for (int i = 0; i < 3; i++) q.push_back(5);
    for (int i = 0; i < 3; i++) q.push_back(10);
    i_enable = 1'b1;
    check_periods(2);
    chk("repeat_level_mid", o_fifo_level, 1);
    check_periods(1);
    chk("repeat_level_after", o_fifo_level, 0);
    check_periods(3);
    i_enable = 1'b0;
    wait_idle();

    // Backpressure: fifth sample waits for the first pop
    i_repeat = 8'd0;
    push(1); push(2); push(3); push(4);
    q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(4); q.push_back(11);
    i_s_valid = 1'b1;
    i_s_data  = 4'd11;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", o_s_ready, 0);
      chk("bp_level_full", o_fifo_level, 4);
      @(negedge clk);
    end
    i_enable = 1'b1;
    @(negedge clk);
    chk("bp_ready_prime", o_s_ready, 0);
    @(negedge clk);
    chk("bp_ready_after_pop", o_s_ready, 1);
    chk("bp_level_after_pop", o_fifo_level, 3);
    chk("bp_first_strobe", o_period_start, 1);
    exp = (q.size() != 0) ? q.pop_front() : -1;
    chk("bp_first_duty", 32'(o_duty), exp);
    @(negedge clk);
    i_s_valid = 1'b0;
    chk("bp_level_refill", o_fifo_level, 4);
    check_periods(4);

    // Asynchronous reset mid-run while pwm_out is high
    chk("pre_reset_pwm", o_pwm_out, 1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("async_pwm", o_pwm_out, 0);
    chk("async_busy", o_busy, 0);
    chk("async_level", o_fifo_level, 0);
    chk("async_duty", o_duty, 0);
    chk("async_underflow", o_underflow, 0);
    chk("async_ready", o_s_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
